// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master.
package apb_master_pkg;

  localparam int unsigned APB_DEFAULT_ADDR_WIDTH     = 32;
  localparam int unsigned APB_DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned APB_DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_master_state_t;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, response out.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without ready.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    sel,
  output logic                    enable,
  output logic                    wr,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strb,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    ready,
  input  logic                    slverr
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_master_state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  // Count holds (ACCESS cycles - 1), so the hit fires on the TIMEOUT_CYCLES-th cycle.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      sel       <= 1'b0;
      enable    <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      strb      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            sel       <= 1'b1;
            wr        <= cmd_wr;
            addr      <= cmd_addr;
            wdata     <= cmd_wdata;
            strb      <= cmd_wr ? cmd_strb : '0;
            state     <= ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        ST_SETUP: begin
          enable <= 1'b1;
          state  <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (ready) begin
            sel       <= 1'b0;
            enable    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= slverr;
            rsp_rdata <= wr ? '0 : rdata;
            state     <= ST_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            sel       <= 1'b0;
            enable    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, shall set the APB and command address width.
REQ-002 Parameter DATA_WIDTH, default 32, shall set the data width; strobe width shall be DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, shall set the ACCESS-phase timeout limit; it is used only under APB_MASTER_TIMEOUT_EN.
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  error flag.
- sel, enable, wr  out  1 each  APB PSEL, PENABLE, PWRITE.
- addr  out  ADDR_WIDTH  APB PADDR.
- wdata  out  DATA_WIDTH  APB PWDATA.
- strb  out  DATA_WIDTH/8  APB PSTRB.
- rdata  in  DATA_WIDTH  APB PRDATA.
- ready  in  1  APB PREADY.
- slverr  in  1  APB PSLVERR.

Function
REQ-005 The FSM shall have states IDLE, SETUP, ACCESS and RESP.
REQ-006 cmd_ready shall be 1 only in IDLE; cmd_valid&cmd_ready shall register wr/addr/wdata/strb and move IDLE->SETUP.
REQ-007 SETUP shall last exactly one cycle, with sel=1 and enable=0, then move to ACCESS.
REQ-008 ACCESS shall drive sel=1 and enable=1 and hold until ready=1 is sampled.
REQ-009 On the ready cycle, the block shall capture slverr into rsp_err and move to RESP.
- Reads: rdata is captured into rsp_rdata.
- Writes: rsp_rdata is set to 0.
REQ-010 addr, wr, wdata and strb shall be stable from SETUP through the final ACCESS cycle and shall hold their values until the next command is accepted.
REQ-011 strb shall be driven all-zero for reads regardless of cmd_strb.
REQ-012 sel and enable shall be 0 in IDLE and RESP; enable shall never be 1 without sel.
REQ-013 RESP shall hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then move to IDLE.
REQ-014 Minimum latency, with ready=1 on the first ACCESS cycle and cmd accepted in cycle N:
- sel=1 in N+1.
- enable=1 in N+2.
- rsp_valid=1 in N+3.
- next cmd_ready=1 in N+4 if rsp_ready=1 in N+3.
REQ-015 Exactly one transfer shall be outstanding; no command is accepted while rsp_valid=1.
REQ-016 ready and slverr shall be ignored outside ACCESS.

Reset
REQ-017 Assertion of rst shall immediately force the following, including mid-transfer (the transfer is dropped, no response):
- state to IDLE;
- sel, enable, wr, rsp_valid and rsp_err to 0;
- addr, wdata, strb and rsp_rdata to 0;
- cmd_ready to 1.
REQ-018 The first command shall be accepted on the first clk edge after rst deasserts.

Configuration
REQ-019 With APB_MASTER_TIMEOUT_EN defined, a counter shall count ACCESS cycles.
- It clears on entry to SETUP.
- When the count reaches TIMEOUT_CYCLES without ready, the transfer is aborted.
- The abort moves to RESP with rsp_err=1 and rsp_rdata=0.
- sel and enable go to 0 the next cycle.
REQ-020 Without APB_MASTER_TIMEOUT_EN, ACCESS shall wait indefinitely and no counter logic shall exist.

Structure
REQ-021 Package apb_master_pkg shall hold the state enum apb_master_state_t and default width constants.
REQ-022 No sub-module shall be used; the FSM, capture registers and optional timer shall live in apb_master.

Verification
REQ-023 The bench shall cover these directed scenarios:
- Write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, ready=1 at once -> sel at N+1, enable at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr=0x20, slave inserts 3 wait states, rdata=0x1234_5678 -> enable held 4 cycles with addr stable, rsp_rdata=0x1234_5678, strb=0.
- Read with slverr=1 on the ready cycle -> rsp_err=1; rsp_valid is held 5 cycles while rsp_ready=0 and no cmd_ready during that time.
- Back-to-back writes with rsp_ready tied 1 -> one transfer per 4 cycles and sel=0 for at least one cycle between transfers.
- rst asserted in ACCESS -> sel, enable and rsp_valid are 0 before the next edge, and no response is produced.
- With APB_MASTER_TIMEOUT_EN and ready held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0.
